// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tick_timer
//  Brief    : Programmable down-counter advanced by a one-cycle tick from the
//             upstream impulse divider. It counts a loaded number of ticks,
//             then raises a one-cycle expiry pulse and a sticky interrupt.
//             Optional auto-reload turns it into a periodic event source.
//  Revision : 1.0  initial release
// ============================================================================
module tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;

    // Timer state machine; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            busy    <= 1'b0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            // Expiry is a single-cycle pulse unless re-asserted below.
            expired <= 1'b0;

            // Clear first so that a same-edge expiry set overrides it.
            if (irq_clr) begin
                irq <= 1'b0;
            end

            if (stop) begin
                // Abort: count is frozen where it was, no expiry reported.
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start) begin
                // Capture a new period; any tick on this edge is discarded.
                reload <= load_val;
                count  <= load_val;
                if (load_val == '0) begin
                    // Zero period expires immediately; never loop on it.
                    expired <= 1'b1;
                    irq     <= 1'b1;
                    busy    <= 1'b0;
                    state   <= auto_reload ? IDLE : DONE;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (tick) begin
                            if (count > WIDTH'(1)) begin
                                count <= count - WIDTH'(1);
                            end else if (count == WIDTH'(1)) begin
                                expired <= 1'b1;
                                irq     <= 1'b1;
                                if (auto_reload) begin
                                    count <= reload;
                                end else begin
                                    count <= '0;
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    DONE: begin
                        count <= '0;
                    end
                    default: begin
                        // IDLE: hold count, ignore ticks.
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
